// File: rtl/uart_rx_frame_chk.sv
// rtl/uart_rx_frame_chk.sv - start/parity/stop bit checker with 3-sample majority voting and saturating error counters
module uart_rx_frame_chk #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int DATA_WIDTH     = 8,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Rx_In,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [PRESCALE_WIDTH-1:0] Edge_Cnt,
    input  logic                      Chk_En,
    input  logic [1:0]                Chk_Type,
    input  logic                      Par_Type,
    input  logic                      Stop_Bits,
    input  logic [DATA_WIDTH-1:0]     Data_In,
    input  logic                      Err_Clr,
    output logic                      Strt_Glitch,
    output logic                      Par_Err,
    output logic                      Stop_Err,
    output logic                      Chk_Done,
    output logic                      Cfg_Err,
    output logic [ERR_CNT_WIDTH-1:0]  Glitch_Cnt,
    output logic [ERR_CNT_WIDTH-1:0]  Par_Err_Cnt,
    output logic [ERR_CNT_WIDTH-1:0]  Stop_Err_Cnt
);
    typedef enum logic [1:0] { IDLE, SAMPLE, STOP_GAP } state_t;

    localparam logic [1:0] CHK_START = 2'b00;
    localparam logic [1:0] CHK_PAR   = 2'b01;
    localparam logic [1:0] CHK_STOP  = 2'b10;
    localparam logic [1:0] CHK_RSVD  = 2'b11;
    localparam int EW = PRESCALE_WIDTH + 1;
    localparam logic [EW-1:0] ONE = EW'(1);
    localparam logic [EW-1:0] TWO = EW'(2);
    localparam logic [PRESCALE_WIDTH-1:0] MIN_PRESCALE = PRESCALE_WIDTH'(4);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

    state_t        state, state_nxt;
    logic [1:0]    type_q;
    logic          two_stop_q, second_q, first_err_q;
    logic [2:0]    smp_q;
    logic [EW-1:0] edge_ext, mid_ext;
    logic          at_s0, at_s1, at_s2, at_dec;
    logic          maj, par_bad, stop_bad;
    logic          decide, final_dec;

    // One extra bit so mid-1 / mid+2 never wrap for any Prescale value
    assign edge_ext = {1'b0, Edge_Cnt};
    assign mid_ext  = {2'b00, Prescale[PRESCALE_WIDTH-1:1]};
    assign at_s0    = (edge_ext + ONE) == mid_ext;
    assign at_s1    = edge_ext == mid_ext;
    assign at_s2    = edge_ext == (mid_ext + ONE);
    assign at_dec   = edge_ext == (mid_ext + TWO);

    assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign par_bad  = maj ^ (^Data_In) ^ Par_Type;
    assign stop_bad = first_err_q | ~maj;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        decide    = 1'b0;
        final_dec = 1'b0;
        case (state)
            IDLE: begin
                if (Chk_En && (Chk_Type != CHK_RSVD) && !Cfg_Err) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!Chk_En || Cfg_Err) begin
                    state_nxt = IDLE;
                end else if (at_dec) begin
                    decide = 1'b1;
                    if ((type_q == CHK_STOP) && two_stop_q && !second_q) begin
                        state_nxt = STOP_GAP;
                    end else begin
                        final_dec = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            STOP_GAP: begin
                if (!Chk_En || Cfg_Err) begin
                    state_nxt = IDLE;
                end else if (Edge_Cnt == '0) begin
                    state_nxt = SAMPLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            type_q      <= CHK_START;
            two_stop_q  <= 1'b0;
            second_q    <= 1'b0;
            first_err_q <= 1'b0;
            smp_q       <= '0;
            Strt_Glitch <= 1'b0;
            Par_Err     <= 1'b0;
            Stop_Err    <= 1'b0;
            Chk_Done    <= 1'b0;
            Cfg_Err     <= 1'b0;
        end else begin
            Cfg_Err  <= Prescale < MIN_PRESCALE;
            Chk_Done <= final_dec;
            if ((state == IDLE) && (state_nxt == SAMPLE)) begin
                type_q      <= Chk_Type;
                two_stop_q  <= Stop_Bits;
                second_q    <= 1'b0;
                first_err_q <= 1'b0;
            end
            // Samples only survive while a bit is actively being sampled
            if ((state == SAMPLE) && (state_nxt == SAMPLE)) begin
                if (at_s0) smp_q[0] <= Rx_In;
                if (at_s1) smp_q[1] <= Rx_In;
                if (at_s2) smp_q[2] <= Rx_In;
            end else begin
                smp_q <= '0;
            end
            if (decide && !final_dec) begin
                second_q    <= 1'b1;
                first_err_q <= ~maj;
            end
            if (final_dec) begin
                case (type_q)
                    CHK_START: Strt_Glitch <= maj;
                    CHK_PAR:   Par_Err     <= par_bad;
                    CHK_STOP:  Stop_Err    <= stop_bad;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Glitch_Cnt   <= '0;
            Par_Err_Cnt  <= '0;
            Stop_Err_Cnt <= '0;
        end else if (Err_Clr) begin
            Glitch_Cnt   <= '0;
            Par_Err_Cnt  <= '0;
            Stop_Err_Cnt <= '0;
        end else if (final_dec) begin
            if ((type_q == CHK_START) && maj && (Glitch_Cnt != CNT_MAX)) begin
                Glitch_Cnt <= Glitch_Cnt + CNT_ONE;
            end
            if ((type_q == CHK_PAR) && par_bad && (Par_Err_Cnt != CNT_MAX)) begin
                Par_Err_Cnt <= Par_Err_Cnt + CNT_ONE;
            end
            if ((type_q == CHK_STOP) && stop_bad && (Stop_Err_Cnt != CNT_MAX)) begin
                Stop_Err_Cnt <= Stop_Err_Cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// tb/tb_uart_rx_frame_chk.sv - randomized self-checking bench for uart_rx_frame_chk
module tb_uart_rx_frame_chk;
    logic       CLK = 1'b0;
    logic       RST;
    logic       Rx_In;
    logic [5:0] Prescale;
    logic [5:0] Edge_Cnt;
    logic       Chk_En;
    logic [1:0] Chk_Type;
    logic       Par_Type;
    logic       Stop_Bits;
    logic [7:0] Data_In;
    logic       Err_Clr;
    logic       Strt_Glitch, Par_Err, Stop_Err, Chk_Done, Cfg_Err;
    logic [7:0] Glitch_Cnt, Par_Err_Cnt, Stop_Err_Cnt;

    uart_rx_frame_chk #(
        .PRESCALE_WIDTH(6),
        .DATA_WIDTH    (8),
        .ERR_CNT_WIDTH (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Rx_In       (Rx_In),
        .Prescale    (Prescale),
        .Edge_Cnt    (Edge_Cnt),
        .Chk_En      (Chk_En),
        .Chk_Type    (Chk_Type),
        .Par_Type    (Par_Type),
        .Stop_Bits   (Stop_Bits),
        .Data_In     (Data_In),
        .Err_Clr     (Err_Clr),
        .Strt_Glitch (Strt_Glitch),
        .Par_Err     (Par_Err),
        .Stop_Err    (Stop_Err),
        .Chk_Done    (Chk_Done),
        .Cfg_Err     (Cfg_Err),
        .Glitch_Cnt  (Glitch_Cnt),
        .Par_Err_Cnt (Par_Err_Cnt),
        .Stop_Err_Cnt(Stop_Err_Cnt)
    );

    always #5 CLK = ~CLK;

    int   total = 0;
    int   bad   = 0;
    int   gcnt, pcnt, scnt;
    logic e_glitch, e_par, e_stop;
    logic clr_at_dec = 1'b0;
    logic [2:0] s1, s2;
    logic [1:0] typ;
    int   nd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".strt_glitch"}, 32'(Strt_Glitch), 32'(e_glitch));
        check({tag, ".par_err"}, 32'(Par_Err), 32'(e_par));
        check({tag, ".stop_err"}, 32'(Stop_Err), 32'(e_stop));
        check({tag, ".glitch_cnt"}, 32'(Glitch_Cnt), gcnt);
        check({tag, ".par_cnt"}, 32'(Par_Err_Cnt), pcnt);
        check({tag, ".stop_cnt"}, 32'(Stop_Err_Cnt), scnt);
    endtask

    function automatic logic maj3(input logic [2:0] s);
        return $countones(s) >= 2;
    endfunction

    function automatic int sat(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    // Drive one bit period: Edge_Cnt 0..Prescale-1, the three sample points carry s[0..2]
    task automatic run_bit(input logic [2:0] s, input logic [1:0] t, input logic hold,
                           input logic [1:0] nxt, input int drop_at, input int rst_at,
                           output int ndone);
        int mid;
        mid   = int'(Prescale) >> 1;
        ndone = 0;
        for (int e = 0; e < int'(Prescale); e++) begin
            Edge_Cnt = 6'(e);
            Chk_En   = ((e <= mid + 2) || hold) && !((drop_at >= 0) && (e >= drop_at));
            Chk_Type = (e <= mid + 2) ? t : nxt;
            if (e == mid - 1)      Rx_In = s[0];
            else if (e == mid)     Rx_In = s[1];
            else if (e == mid + 1) Rx_In = s[2];
            else                   Rx_In = 1'($urandom_range(0, 1));
            Err_Clr = clr_at_dec && (e == mid + 2);
            if (e == rst_at) begin
                RST = 1'b1;
                #2;
                check("rst_async.strt_glitch", 32'(Strt_Glitch), 0);
                check("rst_async.stop_err", 32'(Stop_Err), 0);
                check("rst_async.chk_done", 32'(Chk_Done), 0);
                check("rst_async.glitch_cnt", 32'(Glitch_Cnt), 0);
                check("rst_async.stop_cnt", 32'(Stop_Err_Cnt), 0);
            end else begin
                RST = 1'b0;
            end
            @(posedge CLK);
            #1;
            if (Chk_Done === 1'b1) ndone++;
        end
        Err_Clr = 1'b0;
    endtask

    // Full check (one or two bits) plus reference-model update and comparison
    task automatic do_check(input string tag, input logic [1:0] t, input logic [2:0] a,
                            input logic [2:0] b, input logic hold, input logic [1:0] nxt);
        int   n1, n2, pbit;
        logic two, m1, m2;
        two = (t == 2'b10) && Stop_Bits;
        m1  = maj3(a);
        m2  = maj3(b);
        if (two) begin
            run_bit(a, t, 1'b1, t, -1, -1, n1);
            check({tag, ".first_stop_no_done"}, n1, 0);
            run_bit(b, t, hold, nxt, -1, -1, n2);
        end else begin
            run_bit(a, t, hold, nxt, -1, -1, n2);
        end
        check({tag, ".done_once"}, n2, 1);
        case (t)
            2'b00: begin
                e_glitch = m1;
                if (m1) gcnt = sat(gcnt);
            end
            2'b01: begin
                pbit  = ($countones(Data_In) + int'(Par_Type)) % 2;
                e_par = (int'(m1) != pbit);
                if (e_par) pcnt = sat(pcnt);
            end
            default: begin
                e_stop = two ? (!m1 || !m2) : !m1;
                if (e_stop) scnt = sat(scnt);
            end
        endcase
        if (clr_at_dec) begin
            gcnt = 0;
            pcnt = 0;
            scnt = 0;
        end
        check_all(tag);
    endtask

    initial begin
        RST = 1'b1; Rx_In = 1'b1; Prescale = 6'd8; Edge_Cnt = '0; Chk_En = 1'b0;
        Chk_Type = 2'b00; Par_Type = 1'b0; Stop_Bits = 1'b0; Data_In = '0; Err_Clr = 1'b0;
        gcnt = 0; pcnt = 0; scnt = 0; e_glitch = 0; e_par = 0; e_stop = 0;
        repeat (3) @(posedge CLK);
        #1;
        check_all("reset");
        check("reset.chk_done", 32'(Chk_Done), 0);
        check("reset.cfg_err", 32'(Cfg_Err), 0);
        RST = 1'b0;

        do_check("clean_start", 2'b00, 3'b000, 3'b000, 1'b0, 2'b00);
        do_check("glitch_010", 2'b00, 3'b010, 3'b000, 1'b0, 2'b00);
        check("glitch_010.const", 32'(Strt_Glitch), 0);
        do_check("glitch_110", 2'b00, 3'b011, 3'b000, 1'b0, 2'b00);
        check("glitch_110.const", 32'(Glitch_Cnt), 1);

        Data_In = 8'hA5; Par_Type = 1'b0;
        do_check("par_even", 2'b01, 3'b111, 3'b000, 1'b0, 2'b01);
        check("par_even.const", 32'(Par_Err), 1);
        Par_Type = 1'b1;
        do_check("par_odd", 2'b01, 3'b111, 3'b000, 1'b0, 2'b01);
        check("par_odd.const", 32'(Par_Err), 0);

        Stop_Bits = 1'b1;
        do_check("stop2_second_bad", 2'b10, 3'b111, 3'b000, 1'b0, 2'b10);
        check("stop2_second_bad.const", 32'(Stop_Err), 1);
        do_check("stop2_first_bad", 2'b10, 3'b100, 3'b111, 1'b0, 2'b10);
        do_check("stop2_good", 2'b10, 3'b110, 3'b011, 1'b0, 2'b10);
        Stop_Bits = 1'b0;
        do_check("stop1_bad", 2'b10, 3'b001, 3'b000, 1'b0, 2'b10);

        run_bit(3'b111, 2'b11, 1'b0, 2'b11, -1, -1, nd);
        check("reserved.no_done", nd, 0);
        check_all("reserved");

        Data_In = 8'h3C; Par_Type = 1'b0;
        do_check("b2b_start", 2'b00, 3'b101, 3'b000, 1'b1, 2'b01);
        do_check("b2b_par", 2'b01, 3'b001, 3'b000, 1'b1, 2'b10);
        do_check("b2b_stop", 2'b10, 3'b000, 3'b000, 1'b0, 2'b10);

        for (int k = 0; k < 40; k++) begin
            Prescale  = 6'($urandom_range(5, 16));
            typ       = 2'($urandom_range(0, 2));
            s1        = 3'($urandom_range(0, 7));
            s2        = 3'($urandom_range(0, 7));
            Data_In   = 8'($urandom);
            Par_Type  = 1'($urandom_range(0, 1));
            Stop_Bits = 1'($urandom_range(0, 1));
            do_check("random", typ, s1, s2, 1'b0, typ);
        end
        Prescale = 6'd8; Stop_Bits = 1'b0;

        do_check("pre_abort", 2'b00, 3'b111, 3'b000, 1'b0, 2'b00);
        run_bit(3'b000, 2'b00, 1'b0, 2'b00, 4, -1, nd);
        check("abort_en.no_done", nd, 0);
        check_all("abort_en");

        run_bit(3'b000, 2'b00, 1'b0, 2'b00, -1, 5, nd);
        gcnt = 0; pcnt = 0; scnt = 0; e_glitch = 0; e_par = 0; e_stop = 0;
        check("abort_rst.no_done", nd, 0);
        check_all("abort_rst");
        check("abort_rst.chk_done", 32'(Chk_Done), 0);

        do_check("glitch_before_cfg", 2'b00, 3'b111, 3'b000, 1'b0, 2'b00);
        Prescale = 6'd3;
        #1;
        check("cfg.latency", 32'(Cfg_Err), 0);
        @(posedge CLK);
        #1;
        check("cfg.err_set", 32'(Cfg_Err), 1);
        run_bit(3'b000, 2'b00, 1'b0, 2'b00, -1, -1, nd);
        check("cfg.no_done", nd, 0);
        check_all("cfg");
        Prescale = 6'd8;
        @(posedge CLK);
        #1;
        check("cfg.err_clear", 32'(Cfg_Err), 0);

        for (int k = 0; k < 258; k++) begin
            do_check("saturate", 2'b00, 3'b111, 3'b000, 1'b0, 2'b00);
        end
        check("saturate.const", 32'(Glitch_Cnt), 255);

        clr_at_dec = 1'b1;
        do_check("clr_vs_inc", 2'b00, 3'b111, 3'b000, 1'b0, 2'b00);
        clr_at_dec = 1'b0;
        check("clr_vs_inc.const", 32'(Glitch_Cnt), 0);
        do_check("after_clr", 2'b00, 3'b111, 3'b000, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_chk.md
UART_RX_FRAME_CHK -- requirements
Module: uart_rx_frame_chk

Interface
REQ-001 The block SHALL have parameter PRESCALE_WIDTH, default 6, which sets the width of Prescale and Edge_Cnt.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, which sets the width of the received data word used for the parity check.
REQ-003 The block SHALL have parameter ERR_CNT_WIDTH, default 8, which sets the width of each error counter.
REQ-004 Port CLK  in  1  SHALL be the single clock; the block SHALL use the rising edge only.
REQ-005 Port RST  in  1  SHALL be the reset; it is asynchronous and active-high.
REQ-006 Port Rx_In  in  1  SHALL be the serial line, already synchronised to CLK.
REQ-007 Port Prescale  in  PRESCALE_WIDTH  SHALL give the oversampling ratio (CLK edges per bit).
REQ-008 Port Edge_Cnt  in  PRESCALE_WIDTH  SHALL give the edge index within the current bit, running 0..Prescale-1.
REQ-009 Port Chk_En  in  1  SHALL be the check enable from the Rx controller.
REQ-010 Port Chk_Type  in  2  SHALL select the check: 00 start, 01 parity, 10 stop, 11 reserved.
REQ-011 Port Par_Type  in  1  SHALL select parity: 0 even, 1 odd.
REQ-012 Port Stop_Bits  in  1  SHALL select the stop-bit count: 0 one stop bit, 1 two stop bits.
REQ-013 Port Data_In  in  DATA_WIDTH  SHALL carry the received data word, stable during a parity check.
REQ-014 Port Err_Clr  in  1  SHALL be a synchronous clear for all error counters.
REQ-015 Port Strt_Glitch  out  1  SHALL flag a start-bit glitch.
REQ-016 Port Par_Err  out  1  SHALL flag a parity error.
REQ-017 Port Stop_Err  out  1  SHALL flag a stop-bit (framing) error.
REQ-018 Port Chk_Done  out  1  SHALL be a one-cycle pulse at the final decision of a check.
REQ-019 Port Cfg_Err  out  1  SHALL be high while Prescale < 4.
REQ-020 Ports Glitch_Cnt, Par_Err_Cnt and Stop_Err_Cnt  out  ERR_CNT_WIDTH each  SHALL be saturating error counters.

Function
REQ-021 Sampling SHALL use mid = Prescale>>1, with the samples and the decision point computed as follows:
- samples taken at Edge_Cnt == mid-1, mid and mid+1;
- decision made at Edge_Cnt == mid+2;
- all compares done in PRESCALE_WIDTH+1 bits, with no wrap-around.
REQ-022 The bit value SHALL be the 2-of-3 majority of the three samples.
REQ-023 The FSM SHALL have exactly three states: IDLE, SAMPLE and STOP_GAP.
REQ-024 The FSM SHALL move IDLE->SAMPLE when Chk_En=1, Chk_Type!=11 and Cfg_Err=0, latching Chk_Type and Stop_Bits on that edge.
REQ-025 When Chk_Type=11, the FSM SHALL stay in IDLE and no output SHALL change.
REQ-026 At the decision edge in SAMPLE, the block SHALL register the result as follows:
- start: Strt_Glitch <= (majority != 0);
- parity: Par_Err <= (majority != (^Data_In ^ Par_Type));
- stop, first bit: Stop_Err <= (majority != 1).
REQ-027 For a stop check with latched Stop_Bits=1, the first decision SHALL:
- go SAMPLE->STOP_GAP without pulsing Chk_Done;
- then go STOP_GAP->SAMPLE on Edge_Cnt == 0.
REQ-028 The second stop decision SHALL update Stop_Err <= first_error | (majority != 1).
REQ-029 The final decision SHALL pulse Chk_Done for exactly one cycle, in the same cycle the flag updates, and SHALL return the FSM to IDLE.
REQ-030 Each error flag SHALL hold its value until the next final decision of the same type.
REQ-031 Each counter SHALL increment by 1 when its flag is registered as 1 on a final decision, and SHALL saturate at all-ones.
REQ-032 Err_Clr SHALL zero all counters; when Err_Clr coincides with an increment, the clear SHALL win.
REQ-033 Chk_En=0 in SAMPLE or STOP_GAP SHALL:
- return the FSM to IDLE at the next edge;
- discard any partial samples;
- leave the flags and counters unchanged;
- produce no Chk_Done.
REQ-034 With Chk_En held high, back-to-back checks on consecutive bits SHALL be supported, with Chk_Type re-latched on each IDLE->SAMPLE entry.
REQ-035 When Cfg_Err=1 in SAMPLE or STOP_GAP, the FSM SHALL return to IDLE with no decision.
REQ-036 Cfg_Err SHALL be registered, with one cycle of latency from a Prescale change.

Reset
REQ-037 While RST=1, the block SHALL hold the following state:
- FSM in IDLE;
- sample registers cleared;
- Strt_Glitch, Par_Err, Stop_Err, Chk_Done and Cfg_Err all 0;
- all counters 0.
REQ-038 RST asserted mid-check SHALL abort the check immediately, with no Chk_Done and no counter update.
REQ-039 On RST deassertion, the first Chk_Done SHALL require a full new check.

Verification
REQ-040 Clean start: Prescale=8, Rx_In=0 at Edge_Cnt 3,4,5, Chk_Type=00 -> at Edge_Cnt 6: Strt_Glitch=0, Chk_Done pulses, Glitch_Cnt=0.
REQ-041 Single-sample glitch: samples 0,1,0 -> Strt_Glitch=0; samples 1,1,0 -> Strt_Glitch=1 and Glitch_Cnt=1.
REQ-042 Parity: Data_In=8'hA5, Par_Type=0, Rx_In=1 -> Par_Err=1; the same case with Par_Type=1 -> Par_Err=0.
REQ-043 Two stop bits: Stop_Bits=1, first bit good, second bit majority 0 -> Stop_Err=1, Chk_Done pulses only once, after the second bit.
REQ-044 Counters: 255 glitches plus 1 more with ERR_CNT_WIDTH=8 -> Glitch_Cnt stays at 255; Err_Clr in the same cycle as an increment -> Glitch_Cnt=0.
REQ-045 Aborts:
- Chk_En dropped at Edge_Cnt 4 -> no Chk_Done and flags unchanged;
- RST pulsed at Edge_Cnt 5 -> all outputs 0;
- Prescale=3 -> Cfg_Err=1 and no check starts.
